// File: rtl/serial_cmd_rx.sv
// UART (8N1) command receiver: oversampled byte capture, 0xA0-0xA3 decode,
// and a one-entry valid/ready holding register with sticky overrun.
module serial_cmd_rx #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RxD,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_opcode,
    output logic       frame_err,
    output logic       bad_cmd,
    output logic       overrun
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t          state_q;
    logic [1:0]      sync_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      idx_q;
    logic [7:0]      shreg_q;
    logic            frame_err_q;
    logic            bad_cmd_q;
    logic            valid_q, valid_d;
    logic [1:0]      op_q, op_d;
    logic            ovr_q, ovr_d;

    logic rxs, tick, stop_ok, good, new_cmd, bad, accept;

    assign rxs     = sync_q[1];
    assign tick    = (cnt_q == '0);
    assign stop_ok = (state_q == STOP) && tick && rxs;
    assign good    = (shreg_q[7:4] == 4'hA) && (shreg_q[3:2] == 2'b00);
    assign new_cmd = stop_ok && good;
    assign bad     = stop_ok && !good;
    assign accept  = valid_q && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RxD};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_q <= START;
                        cnt_q   <= HALF;
                    end
                end
                START: begin
                    if (tick) begin
                        cnt_q <= FULL;
                        if (rxs) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            idx_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                DATA: begin
                    if (tick) begin
                        cnt_q          <= FULL;
                        shreg_q[idx_q] <= rxs;
                        if (idx_q == 3'd7) state_q <= STOP;
                        else               idx_q   <= idx_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                STOP: begin
                    if (tick) begin
                        cnt_q <= FULL;
                        if (rxs) begin
                            state_q <= IDLE;
                        end else begin
                            state_q     <= WAIT_HIGH;
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - ONE;
                    end
                end
                WAIT_HIGH: begin
                    if (rxs) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A new command lands only if the slot is empty or being drained this cycle.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        ovr_d   = ovr_q;
        if (new_cmd) begin
            if (!valid_q || accept) begin
                valid_d = 1'b1;
                op_d    = shreg_q[1:0];
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            op_q      <= 2'b00;
            ovr_q     <= 1'b0;
            bad_cmd_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            op_q      <= op_d;
            ovr_q     <= ovr_d;
            bad_cmd_q <= bad;
        end
    end

    assign cmd_valid  = valid_q;
    assign cmd_opcode = op_q;
    assign frame_err  = frame_err_q;
    assign bad_cmd    = bad_cmd_q;
    assign overrun    = ovr_q;
endmodule

// File: doc/serial_cmd_rx.md
SERIAL_CMD_RX -- requirements
Module: serial_cmd_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate; DIV = CLK_HZ/BAUD (integer divide), DIV >= 4.
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 RxD  input  1  asynchronous UART line, 8N1, idle high, LSB first.
REQ-006 cmd_ready  input  1  consumer (top controller) accepts the held command this cycle.
REQ-007 cmd_valid  output  1  a decoded command is held and offered.
REQ-008 cmd_opcode  output  2  measurement opcode of the held command.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 bad_cmd  output  1  one-cycle pulse: well-framed byte failed decode.
REQ-011 overrun  output  1  sticky: a valid command was dropped because the holding register was full.

Function
REQ-012 RxD passes through a 2-flop synchronizer; all line decisions use the synchronized value (rxs).
REQ-013 States: IDLE, START, DATA, STOP, WAIT_HIGH; one baud counter (ceil(log2 DIV) bits) and a 3-bit bit index.
REQ-014 IDLE: rxs=0 -> START, counter loaded with DIV/2-1.
REQ-015 Counter decrements every cycle outside IDLE/WAIT_HIGH; a "sample tick" is the cycle the counter is 0, after which it reloads DIV-1.
REQ-016 START tick: rxs=1 -> IDLE (glitch rejected, no pulse); rxs=0 -> DATA, bit index 0.
REQ-017 DATA tick: rxs shifted into shift register bit [index]; index 7 -> STOP, else index+1.
REQ-018 STOP tick: rxs=1 -> byte complete, IDLE; rxs=0 -> frame_err pulse, byte discarded, WAIT_HIGH.
REQ-019 WAIT_HIGH: remain until rxs=1, then IDLE.
REQ-020 Decode of a complete byte b: valid iff b[7:4]=4'hA and b[3:2]=2'b00; opcode = b[1:0]; otherwise bad_cmd pulses on the cycle after the STOP tick.
REQ-021 A valid command is written to the one-entry holding register on the cycle after the STOP tick; cmd_valid rises that cycle.
REQ-022 cmd_valid/cmd_opcode remain stable while cmd_valid=1 and cmd_ready=0.
REQ-023 Handshake completes on a cycle with cmd_valid=1 and cmd_ready=1; cmd_valid falls next cycle unless a new command is written that same cycle.
REQ-024 Simultaneous accept and new valid command: new opcode loaded, cmd_valid stays 1, overrun unchanged.
REQ-025 New valid command while held and not accepted that cycle: new command dropped, held command unchanged, overrun set.
REQ-026 cmd_ready while cmd_valid=0 has no effect.
REQ-027 Back-to-back frames: a start edge seen in the cycle after the STOP tick is accepted (no extra idle bit required).

Reset
REQ-028 rst=1 at any clock edge, including mid-frame: state IDLE, counters/index/shift register 0, synchronizer flops 1, cmd_valid 0, cmd_opcode 0, frame_err 0, bad_cmd 0, overrun 0.
REQ-029 rst takes priority over every other event; a frame in progress at reset is abandoned without a pulse.

Verification (CLK_HZ=1_000_000, BAUD=100_000, DIV=10)
REQ-030 Send 0xA2 with cmd_ready=0 -> cmd_valid=1, cmd_opcode=2'b10 held; assert cmd_ready one cycle -> cmd_valid=0 next cycle, no pulses.
REQ-031 Send 0x53 (good framing) -> one bad_cmd pulse, cmd_valid stays 0.
REQ-032 Send 0xA1 with stop bit forced low, then line high 20 cycles, then 0xA3 -> one frame_err pulse, then cmd_valid=1, cmd_opcode=2'b11.
REQ-033 RxD low for 3 cycles then high -> no state beyond START, no pulse, no cmd_valid; next 0xA0 decodes normally.
REQ-034 Send 0xA1 then 0xA2 back-to-back with cmd_ready=0 -> opcode stays 2'b01, overrun=1; repeat with cmd_ready pulsed on the second write cycle -> opcode 2'b10, cmd_valid=1, overrun=0.
REQ-035 Assert rst during DATA bit 4 of 0xA3 -> all outputs 0 next cycle; following 0xA0 decodes to cmd_opcode=2'b00.
